// File: rtl/udm_gpio_regs_if.sv
// UDM bus bundle between a bus master (udm_memsplit side) and a GPIO register slave.
interface udm_gpio_regs_if;
  // Handshake: a request is accepted in any cycle where bus_req_i and bus_ack_o are both high.
  // Writes complete at that edge with no response. Reads return bus_resp_o=1 with bus_rdata_bo
  // exactly one cycle later. There are no wait states, so reads may issue every cycle.
  logic        bus_req_i;
  logic        bus_we_i;
  logic [31:0] bus_addr_bi;
  logic [3:0]  bus_be_bi;
  logic [31:0] bus_wdata_bi;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;

  modport master (
    output bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    input  bus_ack_o, bus_resp_o, bus_rdata_bo
  );

  modport slave (
    input  bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    output bus_ack_o, bus_resp_o, bus_rdata_bo
  );
endinterface

// File: rtl/udm_gpio_regs.sv
// Memory-mapped GPIO slave: OUT registers, synchronised IN ports and sticky CHG registers.
// Define GPIO_IRQ_EN to add the IRQ_MASK register and the irq_o output.
module udm_gpio_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int NUM_OUT = 1,
  parameter int NUM_IN  = 1,
  parameter int GPIO_W  = 16,
  parameter logic [GPIO_W-1:0] OUT_RST = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  udm_gpio_regs_if.slave            bus,
  input  logic [NUM_IN*GPIO_W-1:0]  gpio_in_bi,
  output logic [NUM_OUT*GPIO_W-1:0] gpio_out_bo
`ifdef GPIO_IRQ_EN
  ,
  output logic                      irq_o
`endif
);

  typedef logic [GPIO_W-1:0] word_t;

  localparam logic [31:0] ID_VAL = {8'h47, 8'(NUM_OUT), 8'(NUM_IN), 8'(GPIO_W)};

  // Byte-lane merge of a bus write into a GPIO_W-wide register; bits above GPIO_W are dropped.
  function automatic word_t lane_merge(input word_t old_v, input logic [31:0] wd,
                                       input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return word_t'((32'(old_v) & ~m) | (wd & m));
  endfunction

  logic [7:0]  off;
  logic [3:0]  idx;
  logic [1:0]  region;
  logic        hit;
  logic        wr_acc;
  logic        rd_acc;
  logic [31:0] clr_mask;
  logic [31:0] rd_word;
  logic [1:0]  unused_addr_bits;

  word_t out_q   [NUM_OUT];
  word_t out_d   [NUM_OUT];
  word_t sync1_q [NUM_IN];
  word_t sync2_q [NUM_IN];
  word_t prev_q  [NUM_IN];
  word_t chg_q   [NUM_IN];
  word_t chg_d   [NUM_IN];

  logic [1:0]  settle_q, settle_d;
  logic        settled;
  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;

`ifdef GPIO_IRQ_EN
  word_t mask_q, mask_d;
  logic  irq_q, irq_d;
`endif

  assign off              = bus.bus_addr_bi[7:0];
  assign idx              = off[5:2];
  assign region           = off[7:6];
  assign unused_addr_bits = bus.bus_addr_bi[1:0];
  assign hit              = (bus.bus_addr_bi[31:8] == BASE_ADDR[31:8]);
  assign bus.bus_ack_o    = bus.bus_req_i & hit;
  assign wr_acc           = bus.bus_ack_o & bus.bus_we_i;
  assign rd_acc           = bus.bus_ack_o & ~bus.bus_we_i;
  assign clr_mask         = bus.bus_wdata_bi & {{8{bus.bus_be_bi[3]}}, {8{bus.bus_be_bi[2]}},
                                                {8{bus.bus_be_bi[1]}}, {8{bus.bus_be_bi[0]}}};
  assign settled          = (settle_q == 2'd3);

  assign bus.bus_resp_o   = resp_q;
  assign bus.bus_rdata_bo = rdata_q;

  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      gpio_out_bo[i*GPIO_W +: GPIO_W] = out_q[i];
    end
  end

  // Register updates: OUT writes, CHG clear-then-set so a same-cycle change beats the clear.
  always_comb begin
    settle_d = settled ? settle_q : settle_q + 2'd1;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_d[i] = out_q[i];
      if (wr_acc && region == 2'd0 && idx == 4'(i)) begin
        out_d[i] = lane_merge(out_q[i], bus.bus_wdata_bi, bus.bus_be_bi);
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      chg_d[i] = chg_q[i];
      if (wr_acc && region == 2'd2 && idx == 4'(i)) begin
        chg_d[i] = chg_d[i] & ~word_t'(clr_mask);
      end
      if (settled) begin
        chg_d[i] = chg_d[i] | (sync2_q[i] ^ prev_q[i]);
      end
    end
  end

  // Read mux samples pre-edge register values; unmapped slots read as zero.
  always_comb begin
    rd_word = '0;
    case (region)
      2'd0: for (int i = 0; i < NUM_OUT; i++) if (idx == 4'(i)) rd_word = 32'(out_q[i]);
      2'd1: for (int i = 0; i < NUM_IN; i++)  if (idx == 4'(i)) rd_word = 32'(sync2_q[i]);
      2'd2: for (int i = 0; i < NUM_IN; i++)  if (idx == 4'(i)) rd_word = 32'(chg_q[i]);
      default: begin
        if (off == 8'hFC) rd_word = ID_VAL;
`ifdef GPIO_IRQ_EN
        if (off == 8'hC0) rd_word = 32'(mask_q);
`endif
      end
    endcase
    resp_d  = rd_acc;
    rdata_d = rd_acc ? rd_word : 32'h0;
  end

`ifdef GPIO_IRQ_EN
  always_comb begin
    mask_d = mask_q;
    if (wr_acc && off == 8'hC0) begin
      mask_d = lane_merge(mask_q, bus.bus_wdata_bi, bus.bus_be_bi);
    end
    irq_d = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      irq_d = irq_d | (|(chg_q[i] & mask_q));
    end
  end

  assign irq_o = irq_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= OUT_RST;
      for (int i = 0; i < NUM_IN; i++) begin
        sync1_q[i] <= '0;
        sync2_q[i] <= '0;
        prev_q[i]  <= '0;
        chg_q[i]   <= '0;
      end
      settle_q <= 2'd0;
      resp_q   <= 1'b0;
      rdata_q  <= 32'h0;
`ifdef GPIO_IRQ_EN
      mask_q   <= '0;
      irq_q    <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= out_d[i];
      for (int i = 0; i < NUM_IN; i++) begin
        sync1_q[i] <= gpio_in_bi[i*GPIO_W +: GPIO_W];
        sync2_q[i] <= sync1_q[i];
        prev_q[i]  <= sync2_q[i];
        chg_q[i]   <= chg_d[i];
      end
      settle_q <= settle_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
`ifdef GPIO_IRQ_EN
      mask_q   <= mask_d;
      irq_q    <= irq_d;
`endif
    end
  end

endmodule
